// File: rtl/updi_target_pkg.sv
// Shared types and constants for the UPDI target responder.
// State encoding, framing bytes and opcode decode masks.
package updi_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ADDR_L,
    ADDR_H,
    DATA,
    MEM_ACCESS,
    SEND_DATA,
    SEND_ACK
  } state_t;

  localparam logic [7:0] SYNC = 8'h55;
  localparam logic [7:0] ACK  = 8'h40;

  localparam logic [7:0] OP_CS_MASK = 8'hF0;
  localparam logic [7:0] OP_LDCS    = 8'h80;
  localparam logic [7:0] OP_STCS    = 8'hC0;
  localparam logic [7:0] OP_DS_MASK = 8'hFB;
  localparam logic [7:0] OP_LDS     = 8'h00;
  localparam logic [7:0] OP_STS     = 8'h40;

  localparam int OP_A16_BIT = 2;
  localparam int OP_ST_BIT  = 6;

endpackage

// File: rtl/updi_target_cs_regs.sv
// 16 x 8 control/status file for the UPDI target.
// Address 0 is a read-only revision byte; 1..15 are plain registers.
module updi_target_cs_regs #(
  parameter logic [7:0] UPDI_REV = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] regs [16];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && waddr != 4'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == 4'd0) ? UPDI_REV : regs[raddr];

endmodule

// File: rtl/updi_target_responder.sv
// UPDI target-side frame responder between UART FIFOs and a memory port.
// Optional idle timeout enabled by defining UPDI_TARGET_TIMEOUT_EN.
module updi_target_responder
  import updi_target_pkg::*;
#(
  parameter int         MEM_ADDR_BITS  = 16,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] UPDI_REV       = 8'h30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_fifo_data,
  input  logic                     rx_fifo_empty,
  output logic                     rx_fifo_rd_en,
  output logic [7:0]               tx_fifo_data,
  output logic                     tx_fifo_wr_en,
  input  logic                     tx_fifo_full,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [7:0]               mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     frame_error
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state;
  logic        run;
  logic [15:0] addr;
  logic        is_cs;
  logic        is_write;
  logic        two_byte;
  logic        ack_to_data;
  logic [3:0]  cs_sel;
  logic [7:0]  cs_rdata;
  logic        cs_we;
  logic        pop;
  logic        push;
  logic        expired;

  // run keeps rd_en low through the reset cycle
  assign rx_fifo_rd_en = run && (state inside {IDLE, OPCODE, ADDR_L, ADDR_H, DATA});
  assign pop  = rx_fifo_rd_en && !rx_fifo_empty;
  assign push = tx_fifo_wr_en && !tx_fifo_full;
  assign busy = (state != IDLE);
  assign mem_addr = MEM_ADDR_BITS'(addr);
  assign cs_we = pop && (state == DATA) && is_cs;

  updi_target_cs_regs #(
    .UPDI_REV(UPDI_REV)
  ) u_cs (
    .clk   (clk),
    .rst   (rst),
    .raddr (rx_fifo_data[3:0]),
    .rdata (cs_rdata),
    .we    (cs_we),
    .waddr (cs_sel),
    .wdata (rx_fifo_data)
  );

`ifdef UPDI_TARGET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  assign expired = (state != IDLE) && (state != MEM_ACCESS) &&
                   !pop && !push && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || state == IDLE || state == MEM_ACCESS || pop || push) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      run           <= 1'b0;
      addr          <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      tx_fifo_data  <= '0;
      tx_fifo_wr_en <= 1'b0;
      frame_error   <= 1'b0;
      is_cs         <= 1'b0;
      is_write      <= 1'b0;
      two_byte      <= 1'b0;
      ack_to_data   <= 1'b0;
      cs_sel        <= '0;
    end else begin
      run         <= 1'b1;
      frame_error <= 1'b0;
      if (expired) begin
        state         <= IDLE;
        frame_error   <= 1'b1;
        tx_fifo_wr_en <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (pop && rx_fifo_data == SYNC) state <= OPCODE;
          OPCODE: if (pop) begin
            cs_sel   <= rx_fifo_data[3:0];
            is_cs    <= 1'b0;
            is_write <= rx_fifo_data[OP_ST_BIT];
            two_byte <= rx_fifo_data[OP_A16_BIT];
            unique case (1'b1)
              (rx_fifo_data & OP_CS_MASK) == OP_LDCS: begin
                tx_fifo_data  <= cs_rdata;
                tx_fifo_wr_en <= 1'b1;
                state         <= SEND_DATA;
              end
              (rx_fifo_data & OP_CS_MASK) == OP_STCS: begin
                is_cs <= 1'b1;
                state <= DATA;
              end
              (rx_fifo_data & OP_DS_MASK) == OP_LDS,
              (rx_fifo_data & OP_DS_MASK) == OP_STS: state <= ADDR_L;
              default: begin
                frame_error <= 1'b1;
                state       <= IDLE;
              end
            endcase
          end
          ADDR_L, ADDR_H: if (pop) begin
            if (state == ADDR_L) addr <= {8'h00, rx_fifo_data};
            else                 addr[15:8] <= rx_fifo_data;
            if (state == ADDR_L && two_byte) begin
              state <= ADDR_H;
            end else if (is_write) begin
              tx_fifo_data  <= ACK;
              tx_fifo_wr_en <= 1'b1;
              ack_to_data   <= 1'b1;
              state         <= SEND_ACK;
            end else begin
              mem_re <= 1'b1;
              state  <= MEM_ACCESS;
            end
          end
          DATA: if (pop) begin
            if (is_cs) begin
              state <= IDLE;
            end else begin
              mem_wdata <= rx_fifo_data;
              mem_we    <= 1'b1;
              state     <= MEM_ACCESS;
            end
          end
          MEM_ACCESS: if (mem_ready) begin
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            tx_fifo_wr_en <= 1'b1;
            if (mem_re) begin
              tx_fifo_data <= mem_rdata;
              state        <= SEND_DATA;
            end else begin
              tx_fifo_data <= ACK;
              ack_to_data  <= 1'b0;
              state        <= SEND_ACK;
            end
          end
          SEND_DATA: if (!tx_fifo_full) begin
            tx_fifo_wr_en <= 1'b0;
            state         <= IDLE;
          end
          SEND_ACK: if (!tx_fifo_full) begin
            tx_fifo_wr_en <= 1'b0;
            state         <= ack_to_data ? DATA : IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updi_target_responder.sv
// Bench for updi_target_responder: FIFO/memory stubs, vector table,
// directed corner sequences and a randomized frame-level reference model.
module tb_updi_target_responder;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_fifo_data;
  logic          rx_fifo_empty;
  logic          rx_fifo_rd_en;
  logic [7:0]    tx_fifo_data;
  logic          tx_fifo_wr_en;
  logic          tx_fifo_full;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          mem_ready;
  logic          busy;
  logic          frame_error;

  updi_target_responder #(
    .MEM_ADDR_BITS  (AW),
    .TIMEOUT_CYCLES (16),
    .UPDI_REV       (8'h30)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_fifo_data  (rx_fifo_data),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_rd_en (rx_fifo_rd_en),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_full  (tx_fifo_full),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .busy          (busy),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic [15:0] rd_log[$];
  logic [23:0] wr_log[$];
  int fe_cnt = 0;
  int viol = 0;
  int cur_len = 0;
  int last_len = 0;
  int tx_at_req = 0;
  int stall_now = 0;
  int stall_cfg = 1;
  bit stall_forever = 0;
  bit rand_full = 0;
  bit rand_gap = 0;
  bit hold_full = 0;
  bit use_override = 0;
  logic [7:0] rd_override = 8'h00;
  logic [15:0] q_addr;
  logic [7:0]  q_wd;
  logic        q_re;

  function automatic logic [7:0] mem_hash(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA7;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      if (rx_fifo_rd_en && !rx_fifo_empty) void'(rx_q.pop_front());
      if (tx_fifo_wr_en && !tx_fifo_full) tx_log.push_back(tx_fifo_data);
      if (frame_error) fe_cnt++;
      if (mem_re || mem_we) begin
        if (mem_re && mem_we) viol++;
        if (cur_len == 0) tx_at_req = tx_log.size();
        else if (mem_addr != q_addr || mem_wdata != q_wd || mem_re != q_re) viol++;
        q_addr = mem_addr;
        q_wd   = mem_wdata;
        q_re   = mem_re;
        if (mem_ready) begin
          if (mem_re) rd_log.push_back(mem_addr);
          else        wr_log.push_back({mem_addr, mem_wdata});
          last_len = cur_len + 1;
          cur_len  = 0;
        end else begin
          cur_len++;
        end
      end else begin
        cur_len = 0;
      end
    end else begin
      cur_len = 0;
    end
  end

  always @(negedge clk) begin
    rx_fifo_empty = (rx_q.size() == 0) || (rand_gap && $urandom_range(0, 3) == 0);
    rx_fifo_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    tx_fifo_full  = rand_full ? ($urandom_range(0, 3) == 0) : hold_full;
    if (mem_re || mem_we) begin
      if (cur_len == 0) stall_now = (stall_cfg < 0) ? int'($urandom_range(0, 4)) : stall_cfg;
      mem_ready = !stall_forever && (cur_len >= stall_now);
      mem_rdata = use_override ? rd_override : mem_hash(mem_addr);
    end else begin
      mem_ready = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] txb(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    rd_log.delete();
    wr_log.delete();
    fe_cnt = 0;
    viol = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int quiet = 0;
    int t = 0;
    while (quiet < 3 && t < budget) begin
      @(negedge clk);
      t++;
      if (rx_q.size() == 0 && !busy && !tx_fifo_wr_en) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: not idle after %0d cycles, required idle", nm, t);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {rx_fifo_rd_en, tx_fifo_wr_en, tx_fifo_data, mem_addr, mem_wdata,
         mem_we, mem_re, busy, frame_error}, '0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [63:0] rx;
    int          ntx;
    logic [31:0] tx;
    int          nfe;
  } vec_t;

  vec_t tbl[7];

  logic [7:0] cs_m [16];
  logic [7:0] exp_tx[$];
  logic [15:0] exp_rd[$];
  logic [23:0] exp_wr[$];
  int exp_fe;

  task automatic gen_frame();
    logic [7:0]  op, d;
    logic [15:0] a;
    int          k;
    logic [7:0]  bad_ops [7];
    bad_ops = '{8'h08, 8'h20, 8'hF0, 8'h60, 8'h01, 8'hA0, 8'h10};
    k = $urandom_range(0, 7);
    a = 16'($urandom);
    d = 8'($urandom);
    case (k)
      0: begin
        op = 8'($urandom);
        if (op == 8'h55) op = 8'h56;
        rx_q.push_back(op);
      end
      1: begin
        rx_q.push_back(8'h55);
        rx_q.push_back(8'h80 | {4'h0, a[3:0]});
        exp_tx.push_back(a[3:0] == 0 ? 8'h30 : cs_m[a[3:0]]);
      end
      2: begin
        rx_q.push_back(8'h55);
        rx_q.push_back(8'hC0 | {4'h0, a[3:0]});
        rx_q.push_back(d);
        if (a[3:0] != 0) cs_m[a[3:0]] = d;
      end
      3, 4: begin
        if (k == 3) a[15:8] = 8'h00;
        rx_q.push_back(8'h55);
        rx_q.push_back(k == 3 ? 8'h00 : 8'h04);
        rx_q.push_back(a[7:0]);
        if (k == 4) rx_q.push_back(a[15:8]);
        exp_rd.push_back(a);
        exp_tx.push_back(mem_hash(a));
      end
      5, 6: begin
        if (k == 5) a[15:8] = 8'h00;
        rx_q.push_back(8'h55);
        rx_q.push_back(k == 5 ? 8'h40 : 8'h44);
        rx_q.push_back(a[7:0]);
        if (k == 6) rx_q.push_back(a[15:8]);
        rx_q.push_back(d);
        exp_tx.push_back(8'h40);
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h40);
      end
      default: begin
        rx_q.push_back(8'h55);
        rx_q.push_back(bad_ops[$urandom_range(0, 6)]);
        exp_fe++;
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int stable_bad;
    int t;
    logic [7:0] held;

    rst = 1'b0;
    rx_fifo_empty = 1'b1;
    rx_fifo_data = 8'h00;
    tx_fifo_full = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;

    tbl[0] = '{2, 64'h5580_0000_0000_0000, 1, 32'h3000_0000, 0};
    tbl[1] = '{5, 64'h55C3_A555_8300_0000, 1, 32'hA500_0000, 0};
    tbl[2] = '{4, 64'h00FF_55F0_0000_0000, 0, 32'h0, 1};
    tbl[3] = '{5, 64'h55C0_7755_8000_0000, 1, 32'h3000_0000, 0};
    tbl[4] = '{7, 64'h55CF_5A55_8F55_8300, 2, 32'h5AA5_0000, 0};
    tbl[5] = '{7, 64'h55C1_3C55_8155_2000, 1, 32'h3C00_0000, 1};
    tbl[6] = '{3, 64'h5555_8000_0000_0000, 0, 32'h0, 1};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      clear_logs();
      for (int k = 0; k < tbl[i].n; k++) rx_q.push_back(tbl[i].rx[63-8*k -: 8]);
      wait_done($sformatf("vec%0d_done", i), 200);
      chk($sformatf("vec%0d_tx_count", i), tx_log.size(), tbl[i].ntx);
      for (int k = 0; k < tbl[i].ntx; k++)
        chk($sformatf("vec%0d_tx%0d", i, k), txb(k), tbl[i].tx[31-8*k -: 8]);
      chk($sformatf("vec%0d_frame_error", i), fe_cnt, tbl[i].nfe);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    // STS with 2-byte address: ACK before the write, ACK after it
    clear_logs();
    stall_cfg = 2;
    rx_q = '{8'h55, 8'h44, 8'h34, 8'h12, 8'h7E};
    wait_done("sts_done", 200);
    chk("sts_tx_count", tx_log.size(), 2);
    chk("sts_ack0", txb(0), 8'h40);
    chk("sts_ack1", txb(1), 8'h40);
    chk("sts_ack_before_we", tx_at_req, 1);
    chk("sts_write", wr_log.size() == 1 ? wr_log[0] : 24'hxxxxxx, 24'h12347E);
    chk("sts_protocol", viol, 0);

    // LDS with 3 stall cycles
    clear_logs();
    stall_cfg = 3;
    use_override = 1;
    rd_override = 8'h9C;
    rx_q = '{8'h55, 8'h04, 8'h10, 8'h00};
    wait_done("lds_done", 200);
    chk("lds_re_cycles", last_len, 4);
    chk("lds_addr", rd_log.size() == 1 ? rd_log[0] : 16'hxxxx, 16'h0010);
    chk("lds_tx_count", tx_log.size(), 1);
    chk("lds_tx", txb(0), 8'h9C);
    use_override = 0;
    stall_cfg = 1;

    // TX FIFO full for 10 cycles during an LDCS reply
    clear_logs();
    hold_full = 1;
    rx_q = '{8'h55, 8'h80};
    t = 0;
    while (!tx_fifo_wr_en && t < 30) begin
      @(negedge clk);
      t++;
    end
    held = tx_fifo_data;
    stable_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!tx_fifo_wr_en || tx_fifo_data !== held) stable_bad++;
    end
    chk("full_held_stable", stable_bad, 0);
    chk("full_no_push", tx_log.size(), 0);
    hold_full = 0;
    wait_done("full_done", 100);
    chk("full_tx_count", tx_log.size(), 1);
    chk("full_tx", txb(0), 8'h30);

    // Silence after LDS opcode
    clear_logs();
    rx_q = '{8'h55, 8'h04};
    repeat (10) @(negedge clk);
    chk("silence_early_no_error", fe_cnt, 0);
    repeat (30) @(negedge clk);
`ifdef UPDI_TARGET_TIMEOUT_EN
    chk("timeout_error", fe_cnt, 1);
    chk("timeout_idle", busy, 0);
`else
    chk("silence_no_error", fe_cnt, 0);
    chk("silence_waits", busy, 1);
`endif
    do_reset();
    chk("silence_reset_idle", busy, 0);

    // Reset in the middle of a memory read
    clear_logs();
    stall_forever = 1;
    rx_q = '{8'h55, 8'h00, 8'h10};
    t = 0;
    while (!mem_re && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("midaccess_re_seen", mem_re, 1);
    repeat (2) @(negedge clk);
    do_reset();
    stall_forever = 0;
    repeat (20) @(negedge clk);
    chk("midaccess_no_tx", tx_log.size(), 0);
    chk("midaccess_no_read", rd_log.size(), 0);
    rx_q = '{8'h55, 8'h83};
    wait_done("cs_after_reset_done", 100);
    chk("cs_after_reset", txb(0), 8'h00);

    // Randomized frames against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) cs_m[i] = 8'h00;
    rand_full = 1;
    rand_gap = 1;
    stall_cfg = -1;
    for (int b = 0; b < 3; b++) begin
      clear_logs();
      exp_tx.delete();
      exp_rd.delete();
      exp_wr.delete();
      exp_fe = 0;
      for (int f = 0; f < 20; f++) gen_frame();
      wait_done($sformatf("rand%0d_done", b), 4000);
      chk($sformatf("rand%0d_tx_count", b), tx_log.size(), exp_tx.size());
      for (int k = 0; k < exp_tx.size(); k++)
        chk($sformatf("rand%0d_tx%0d", b, k), txb(k), exp_tx[k]);
      chk($sformatf("rand%0d_rd_count", b), rd_log.size(), exp_rd.size());
      for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++)
        chk($sformatf("rand%0d_rd%0d", b, k), rd_log[k], exp_rd[k]);
      chk($sformatf("rand%0d_wr_count", b), wr_log.size(), exp_wr.size());
      for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
        chk($sformatf("rand%0d_wr%0d", b, k), wr_log[k], exp_wr[k]);
      chk($sformatf("rand%0d_frame_error", b), fe_cnt, exp_fe);
      chk($sformatf("rand%0d_protocol", b), viol, 0);
    end
    rand_full = 0;
    rand_gap = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updi_target_responder.md
UPDI_TARGET_RESPONDER -- requirements
Module: updi_target_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 16, giving the width of the memory address bus.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the inter-byte idle limit in clocks.
REQ-003 SHALL have parameter UPDI_REV, default 8'h30, giving the value returned for CS address 0 (STATUSA).
REQ-004 SHALL have ports, one clock, reset synchronous active-low:
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous active-low reset
- rx_fifo_data  input  8  first-word-fall-through (FWFT) UART RX FIFO head
- rx_fifo_empty  input  1  RX FIFO empty
- rx_fifo_rd_en  output  1  pops RX head this cycle
- tx_fifo_data  output  8  byte to UART TX FIFO
- tx_fifo_wr_en  output  1  push tx_fifo_data
- tx_fifo_full  input  1  TX FIFO full
- mem_addr  output  MEM_ADDR_BITS  target memory address
- mem_wdata  output  8  write data
- mem_we  output  1  write request, held until mem_ready
- mem_re  output  1  read request, held until mem_ready
- mem_rdata  input  8  read data, valid with mem_ready
- mem_ready  input  1  completes the current request
- busy  output  1  high whenever the FSM is not in IDLE
- frame_error  output  1  one-cycle pulse on an unsupported opcode or timeout

Function
REQ-005 SHALL pop an RX byte only when rx_fifo_rd_en && !rx_fifo_empty, consuming rx_fifo_data in that same cycle.
REQ-006 SHALL push a TX byte only when !tx_fifo_full; the byte and wr_en are held until accepted.
REQ-007 SHALL implement FSM states: IDLE, OPCODE, ADDR_L, ADDR_H, DATA, MEM_ACCESS, SEND_DATA, SEND_ACK.
REQ-008 IDLE: pop bytes; on 8'h55 go to OPCODE; discard any other byte silently.
REQ-009 OPCODE decode, by opcode:
- 8'h80|a (LDCS): go to SEND_DATA with CS register a.
- 8'hC0|a (STCS): go to DATA.
- 8'h00 / 8'h04 (LDS, byte data, 1-byte / 2-byte address): go to ADDR_L.
- 8'h40 / 8'h44 (STS, byte data, 1-byte / 2-byte address): go to ADDR_L.
- Any other opcode: pulse frame_error and go to IDLE.
REQ-010 ADDR_L SHALL latch the low address byte, then go to ADDR_H for 2-byte addressing, else continue as for 1-byte addressing below.
REQ-011 ADDR_H SHALL latch the high address byte; bits above MEM_ADDR_BITS are dropped, and the address is zero-extended when MEM_ADDR_BITS > 16.
REQ-012 After the address, LDS SHALL go to MEM_ACCESS (read); STS SHALL emit ACK 8'h40 via SEND_ACK, then go to DATA.
REQ-013 DATA: for STCS, write the byte to CS register a, then go to IDLE with no ACK; for STS, latch the byte and go to MEM_ACCESS (write).
REQ-014 MEM_ACCESS SHALL hold mem_re or mem_we (never both) with stable addr/wdata until mem_ready, then:
- read: capture mem_rdata and go to SEND_DATA.
- write: go to SEND_ACK and emit 8'h40, then go to IDLE.
REQ-015 SEND_DATA SHALL emit one byte, then go to IDLE.
REQ-016 Internal CS file SHALL be 16 x 8:
- address 0 reads UPDI_REV and ignores writes.
- addresses 1..15 are read/write and reset to 0.
REQ-017 The FSM SHALL return to IDLE on the cycle after completing a frame, ready to accept the next 8'h55 one cycle later.

Reset
REQ-018 While rst is low, these SHALL be 0: all outputs, the address/data latches, and CS registers 1..15; the FSM SHALL be in IDLE.
REQ-019 Reset mid-frame or mid-access SHALL abandon the frame immediately; no further byte SHALL be emitted for it.

Configuration
REQ-020 With UPDI_TARGET_TIMEOUT_EN defined, a counter SHALL:
- clear on every pop or push and in IDLE;
- when it reaches TIMEOUT_CYCLES in any non-IDLE state other than MEM_ACCESS, pulse frame_error, drop the frame, and go to IDLE.
REQ-021 Without UPDI_TARGET_TIMEOUT_EN, no counter logic SHALL exist and non-IDLE states SHALL wait indefinitely.

Structure
REQ-022 A shared package updi_target_pkg SHALL hold:
- the state enum;
- the constants SYNC=8'h55, ACK=8'h40;
- the opcode masks/values for LDS/STS/LDCS/STCS.
REQ-023 The CS register file SHALL be a sub-module, updi_target_cs_regs, with a read port and a write port.

Verification
REQ-024 RX 55 80 -> TX 30; busy returns to 0.
REQ-025 RX 55 C3 A5, then 55 83 -> TX A5 only; no ACK after STCS.
REQ-026 RX 55 44 34 12 7E -> TX 40 after address; mem_we with addr 16'h1234, wdata 7E; TX 40 after mem_ready.
REQ-027 RX 55 04 10 00, memory returns 9C after 3 stall cycles -> mem_re held 3+1 cycles, addr 16'h0010; TX 9C.
REQ-028 RX 00 FF 55 F0 -> leading bytes ignored, frame_error pulses once at F0, no TX.
REQ-029 tx_fifo_full held 10 cycles during LDCS reply -> byte stable, pushed once on release; with TIMEOUT_CYCLES=16 and the macro defined, RX 55 04 then silence -> frame_error at 16 idle cycles.
